// File: rtl/inv_key_scheduler.sv
// inv_key_scheduler: loads a 128-bit cipher key, runs one invkeyexpand step
// per cycle for round constants 0..9 and keeps all 11 round keys in a register
// file with a registered, one-cycle-latency read port.
// Optional build macro: INV_KEYSCHED_ABORT_EN (accept during EXPAND restarts).
// invkeyexpand undoes one AES-128 key-expansion round: given round key r it
// returns round key r-1. rc = 0 undoes the last round (rcon 0x36) and rc = 9
// undoes the first (rcon 0x01). Byte 15 ([127:120]) is the first key byte.

module invkeyexpand (
    input  logic [127:0] key,
    input  logic [3:0]   rc,
    output logic [127:0] key_out
);
    localparam logic [0:255][7:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants in the order they are undone.
    localparam logic [0:9][7:0] rcon_tbl = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    logic [7:0]  rcon;

    assign {k0, k1, k2, k3} = key;

    // The three trailing words of the previous round fall out of plain XORs.
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;

    assign rot  = {p3[23:0], p3[31:24]};
    assign sub  = {sbox_tbl[rot[31:24]], sbox_tbl[rot[23:16]],
                   sbox_tbl[rot[15:8]],  sbox_tbl[rot[7:0]]};
    // rc never exceeds 9; the guard only keeps the table index in range.
    assign rcon = (rc <= 4'd9) ? rcon_tbl[rc] : 8'h00;
    assign p0   = k0 ^ sub ^ {rcon, 24'h0};

    assign key_out = {p0, p1, p2, p3};
endmodule

module inv_key_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t       state;
    logic [3:0]   rc;
    logic [127:0] cur;
    logic [127:0] slot [0:10];
    logic [127:0] step_out;
    logic         accept;

    invkeyexpand u_step (
        .key     (cur),
        .rc      (rc),
        .key_out (step_out)
    );

`ifdef INV_KEYSCHED_ABORT_EN
    // A new key may interrupt an expansion in progress.
    assign key_ready = !reset;
`else
    // The producer holds its key until the running expansion finishes.
    assign key_ready = (state != EXPAND) && !reset;
`endif

    assign accept = key_valid && key_ready;
    assign busy   = (state == EXPAND);

    // Controller, round-key register file and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rc       <= 4'd0;
            cur      <= '0;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            // NOTE: the key store is cleared on reset on purpose, so that no
            // key material survives a reset; a plain RAM could not do this.
            for (int i = 0; i <= 10; i++) begin
                slot[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make this read see the slot value
            // from before this edge, so a same-cycle write is never bypassed.
            rk_out <= (rk_idx <= 4'd10) ? slot[rk_idx] : '0;
            done   <= 1'b0;
            if (accept) begin
                slot[0]  <= key_in;
                cur      <= key_in;
                rc       <= 4'd0;
                state    <= EXPAND;
                rk_valid <= 1'b0;
            end else if (state == EXPAND) begin
                slot[rc + 4'd1] <= step_out;
                cur             <= step_out;
                if (rc == 4'd9) begin
                    state    <= READY;
                    rk_valid <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    rc <= rc + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inv_key_scheduler.sv
// Directed bench for inv_key_scheduler. Expected round keys come from an
// algorithmic AES model (S-box built from GF(2^8) inverse + affine map) and
// one published AES-128 vector.

module tb_inv_key_scheduler;
    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         busy;
    logic         done;

    int passes = 0;
    int total  = 0;

    localparam logic [127:0] k0_key   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] k1_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] fips_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [7:0]   sb [0:255];
    logic [127:0] sched [0:2][0:10];

    always #5 clk = ~clk;

    inv_key_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Undo one key-expansion round; step n uses rcon of round 10-n.
    function automatic logic [127:0] model_step(input logic [127:0] k, input int n);
        logic [7:0] rcons [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        logic [31:0] w [0:3];
        logic [31:0] q [0:3];
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        q[3] = w[3] ^ w[2];
        q[2] = w[2] ^ w[1];
        q[1] = w[1] ^ w[0];
        q[0] = w[0] ^ {sb[q[3][23:16]] ^ rcons[9 - n], sb[q[3][15:8]],
                       sb[q[3][7:0]], sb[q[3][31:24]]};
        return {q[0], q[1], q[2], q[3]};
    endfunction

    task automatic build_sched(input int which, input logic [127:0] key);
        sched[which][0] = key;
        for (int n = 0; n < 10; n++) sched[which][n + 1] = model_step(sched[which][n], n);
    endtask

    // One rising edge, then settle to the falling edge for drive and sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Read every index; which < 0 means all slots must read as zero.
    task automatic sweep(input string name, input int which);
        for (int idx = 0; idx < 16; idx++) begin
            rk_idx = 4'(idx);
            tick();
            check($sformatf("%s_rd%0d", name, idx), rk_out,
                  (which >= 0 && idx <= 10) ? sched[which][idx] : 128'h0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_idx    = 4'd0;
        build_sbox();
        build_sched(0, k0_key);
        build_sched(1, k1_key);
        build_sched(2, fips_key);

        // Reset state.
        @(negedge clk);
        tick();
        check("rst_key_ready", key_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rk_valid", rk_valid, 0);
        check("rst_rk_out", rk_out, 0);
        reset = 1'b0;
        tick();
        check("rel_key_ready", key_ready, 1);
        check("rel_busy", busy, 0);

        // K0 expansion, watching slot 4 across its write edge.
        rk_idx    = 4'd4;
        key_valid = 1'b1;
        key_in    = k0_key;
        tick();
        key_valid = 1'b0;
        check("k0_e0_busy", busy, 1);
        check("k0_e0_key_ready", key_ready, 0);
        check("k0_e0_done", done, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("k0_e%0d_busy", i), busy, (i < 10));
            check($sformatf("k0_e%0d_done", i), done, (i == 10));
            check($sformatf("k0_e%0d_rk_valid", i), rk_valid, (i == 10));
            check($sformatf("k0_e%0d_slot4", i), rk_out, (i <= 4) ? 128'h0 : sched[0][4]);
        end
        tick();
        check("k0_done_drop", done, 0);
        check("k0_rk_valid_hold", rk_valid, 1);
        sweep("k0", 0);

        // Published vector: undoing all rounds from the last round key of
        // 000102..0f must give back that key in slot 10. Restart from READY.
        key_valid = 1'b1;
        key_in    = fips_key;
        tick();
        key_valid = 1'b0;
        check("fips_rk_valid_drop", rk_valid, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("fips_e%0d_done", i), done, (i == 10));
        end
        rk_idx = 4'd10;
        tick();
        check("fips_slot10", rk_out, k0_key);
        sweep("fips", 2);

`ifndef INV_KEYSCHED_ABORT_EN
        // Key held during EXPAND is ignored until READY, then taken back to back.
        rk_idx    = 4'd10;
        key_valid = 1'b1;
        key_in    = k0_key;
        tick();
        key_in = k1_key;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("hold_e%0d_key_ready", i), key_ready, (i == 10));
            check($sformatf("hold_e%0d_done", i), done, (i == 10));
        end
        tick();
        key_valid = 1'b0;
        check("hold_k0_slot10", rk_out, sched[0][10]);
        check("hold_k1_rk_valid_drop", rk_valid, 0);
        check("hold_k1_busy", busy, 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("hold_k1_e%0d_done", i), done, (i == 10));
        end
        sweep("hold_k1", 1);
`endif

        // Reset in the middle of an expansion.
        key_valid = 1'b1;
        key_in    = k0_key;
        tick();
        key_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rk_valid", rk_valid, 0);
        check("midrst_key_ready", key_ready, 0);
        check("midrst_rk_out", rk_out, 0);
        reset = 1'b0;
        tick();
        check("midrst_rel_key_ready", key_ready, 1);
        check("midrst_rel_busy", busy, 0);
        check("midrst_rel_done", done, 0);
        sweep("midrst", -1);

`ifdef INV_KEYSCHED_ABORT_EN
        // K1 accepted at E6 of K0 aborts it; one done, 10 cycles after K1.
        key_valid = 1'b1;
        key_in    = k0_key;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        key_valid = 1'b1;
        key_in    = k1_key;
        check("abort_key_ready", key_ready, 1);
        tick();
        key_valid = 1'b0;
        check("abort_busy", busy, 1);
        check("abort_done", done, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("abort_c%0d_done", i), done, (i == 10));
        end
        sweep("abort_k1", 1);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
